// File: rtl/rx_fifo_drain.sv
// Drains the UART receiver's one-byte buffer into a show-ahead FIFO.
// Each entry carries its framing-error tag. Overrun and underflow are held in sticky flags.
module rx_fifo_drain #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             data_ready,
  input  logic             framing_error,
  input  logic             overrun_error,
  output logic             data_read,
  input  logic             pop,
  input  logic             clr_err,
  output logic [7:0]       fifo_rdata,
  output logic             fifo_ferr,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             ovr_sticky,
  output logic             unf_sticky
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             unf_q, unf_d;
  logic [8:0]       mem_q [DEPTH];

  logic push;
  logic pop_ok;

  // full/empty come from the occupancy count because the pointers alias when they wrap
  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign push   = (state_q == ST_IDLE) && data_ready && !full;
  assign pop_ok = pop && !empty;

  always_comb begin
    state_d = ST_IDLE;
    if (push) begin
      state_d = ST_ACK;
    end
    wptr_d  = push   ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    // A set and a clear in the same cycle leave the flag set
    ovr_d   = overrun_error || (ovr_q && !clr_err);
    unf_d   = (pop && empty) || (unf_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset. The gate on n_rst keeps a reset cycle from writing an entry.
  always_ff @(posedge clk) begin
    if (push && !n_rst) begin
      mem_q[wptr_q] <= {framing_error, rx_data};
    end
  end

  assign data_read  = (state_q == ST_ACK);
  assign fifo_rdata = mem_q[rptr_q][7:0];
  assign fifo_ferr  = mem_q[rptr_q][8];
  assign count      = count_q;
  assign ovr_sticky = ovr_q;
  assign unf_sticky = unf_q;

endmodule

// File: tb/tb_rx_fifo_drain.sv
// Directed bench for rx_fifo_drain: one task per scenario, with hand-computed expectations.
module tb_rx_fifo_drain;

  logic       clk;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;
  logic       data_read;
  logic       pop;
  logic       clr_err;
  logic [7:0] fifo_rdata;
  logic       fifo_ferr;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       ovr_sticky;
  logic       unf_sticky;

  int n_cmp;
  int n_bad;

  rx_fifo_drain #(.DEPTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .data_ready(data_ready),
    .framing_error(framing_error), .overrun_error(overrun_error),
    .data_read(data_read), .pop(pop), .clr_err(clr_err),
    .fifo_rdata(fifo_rdata), .fifo_ferr(fifo_ferr), .empty(empty), .full(full),
    .count(count), .ovr_sticky(ovr_sticky), .unf_sticky(unf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait for the acknowledge, then release data_ready
  task automatic send_byte(input logic [7:0] b, input logic fe);
    bit got;
    got = 1'b0;
    rx_data = b;
    framing_error = fe;
    data_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (data_read === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL send_byte_ack: data_read never seen for byte %02h (required 1 within 10 cycles)", b);
    end
    data_ready = 1'b0;
    framing_error = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    n_cmp++;
    if (fifo_rdata !== exp) begin
      n_bad++;
      $display("FAIL %s: fifo_rdata=%02h required %02h", name, fifo_rdata, exp);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
    n_cmp++;
    if ({data_read, count, empty, full, ovr_sticky, unf_sticky} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: dr=%b cnt=%0d e=%b f=%b ovr=%b unf=%b required 0 0 1 0 0 0",
               data_read, count, empty, full, ovr_sticky, unf_sticky);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    rx_data = 8'hA5;
    data_ready = 1'b1;
    tick();
    n_cmp++;
    if ({data_read, count, empty, fifo_rdata, fifo_ferr} !== {1'b1, 4'd1, 1'b0, 8'hA5, 1'b0}) begin
      n_bad++;
      $display("FAIL single_capture: dr=%b cnt=%0d e=%b d=%02h fe=%b required 1 1 0 a5 0",
               data_read, count, empty, fifo_rdata, fifo_ferr);
    end
    data_ready = 1'b0;
    tick();
    n_cmp++;
    if (data_read !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ack_width: data_read=%b required 0", data_read);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    n_cmp++;
    if ({empty, count} !== {1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL single_pop: empty=%b count=%0d required 1 0", empty, count);
    end
    $display("test_single done");
  endtask

  task automatic test_fill_stall();
    bit saw;
    bit got;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    tick();
    n_cmp++;
    if ({full, count} !== {1'b1, 4'd8}) begin
      n_bad++;
      $display("FAIL fill_full: full=%b count=%0d required 1 8", full, count);
    end
    rx_data = 8'h09;
    data_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_read !== 1'b0) saw = 1'b1;
    end
    n_cmp++;
    if (saw || count !== 4'd8) begin
      n_bad++;
      $display("FAIL fill_stall: data_read pulsed=%b count=%0d required 0 8", saw, count);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    n_cmp++;
    if (fifo_rdata !== 8'h02) begin
      n_bad++;
      $display("FAIL fill_head_after_pop: fifo_rdata=%02h required 02", fifo_rdata);
    end
    got = (data_read === 1'b1);
    if (!got) begin
      tick();
      got = (data_read === 1'b1);
    end
    n_cmp++;
    if (!got || count !== 4'd8) begin
      n_bad++;
      $display("FAIL fill_resume: data_read seen=%b count=%0d required 1 8", got, count);
    end
    data_ready = 1'b0;
    tick();
    for (int i = 2; i <= 9; i++) pop_check("fill_order", 8'(i));
    n_cmp++;
    if ({empty, count} !== {1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL fill_drained: empty=%b count=%0d required 1 0", empty, count);
    end
    $display("test_fill_stall done");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    tick();
    for (int i = 0; i < 3; i++) pop_check("wrap_pre", 8'hE0 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i), 1'b0);
      n_cmp++;
      if (count !== 4'(i + 1)) begin
        n_bad++;
        $display("FAIL wrap_count_up: count=%0d required %0d", count, i + 1);
      end
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      pop_check("wrap_order", 8'h10 + 8'(i));
      n_cmp++;
      if (count !== 4'(7 - i)) begin
        n_bad++;
        $display("FAIL wrap_count_down: count=%0d required %0d", count, 7 - i);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_errors();
    send_byte(8'h3C, 1'b1);
    tick();
    n_cmp++;
    if ({fifo_ferr, fifo_rdata} !== {1'b1, 8'h3C}) begin
      n_bad++;
      $display("FAIL err_ferr_tag: fe=%b d=%02h required 1 3c", fifo_ferr, fifo_rdata);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    overrun_error = 1'b1;
    tick();
    overrun_error = 1'b0;
    n_cmp++;
    if (ovr_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL err_ovr_set: ovr_sticky=%b required 1", ovr_sticky);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    n_cmp++;
    if ({unf_sticky, count} !== {1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL err_unf_set: unf=%b count=%0d required 1 0", unf_sticky, count);
    end
    clr_err = 1'b1;
    overrun_error = 1'b1;
    tick();
    overrun_error = 1'b0;
    clr_err = 1'b0;
    n_cmp++;
    if ({ovr_sticky, unf_sticky} !== 2'b10) begin
      n_bad++;
      $display("FAIL err_set_wins: ovr=%b unf=%b required 1 0", ovr_sticky, unf_sticky);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++;
    if ({ovr_sticky, unf_sticky} !== 2'b00) begin
      n_bad++;
      $display("FAIL err_clear: ovr=%b unf=%b required 0 0", ovr_sticky, unf_sticky);
    end
    $display("test_errors done");
  endtask

  task automatic test_simultaneous();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    tick();
    rx_data = 8'hA4;
    data_ready = 1'b1;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    data_ready = 1'b0;
    n_cmp++;
    if ({count, data_read, fifo_rdata} !== {4'd3, 1'b1, 8'hA2}) begin
      n_bad++;
      $display("FAIL simul_mid: cnt=%0d dr=%b d=%02h required 3 1 a2", count, data_read, fifo_rdata);
    end
    tick();
    pop_check("simul_order", 8'hA2);
    pop_check("simul_order", 8'hA3);
    pop_check("simul_order", 8'hA4);
    rx_data = 8'hB0;
    data_ready = 1'b1;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    data_ready = 1'b0;
    n_cmp++;
    if ({count, unf_sticky, data_read, fifo_rdata} !== {4'd1, 1'b1, 1'b1, 8'hB0}) begin
      n_bad++;
      $display("FAIL simul_empty: cnt=%0d unf=%b dr=%b d=%02h required 1 1 1 b0",
               count, unf_sticky, data_read, fifo_rdata);
    end
    tick();
    pop_check("simul_empty_pop", 8'hB0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid_ack();
    overrun_error = 1'b1;
    tick();
    overrun_error = 1'b0;
    rx_data = 8'hC3;
    data_ready = 1'b1;
    tick();
    n_cmp++;
    if ({data_read, count, ovr_sticky} !== {1'b1, 4'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_ack_setup: dr=%b cnt=%0d ovr=%b required 1 1 1", data_read, count, ovr_sticky);
    end
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    n_cmp++;
    if ({data_read, count, empty, ovr_sticky, unf_sticky} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid_ack: dr=%b cnt=%0d e=%b ovr=%b unf=%b required 0 0 1 0 0",
               data_read, count, empty, ovr_sticky, unf_sticky);
    end
    tick();
    n_cmp++;
    if ({data_read, count, fifo_rdata} !== {1'b1, 4'd1, 8'hC3}) begin
      n_bad++;
      $display("FAIL rst_recapture: dr=%b cnt=%0d d=%02h required 1 1 c3", data_read, count, fifo_rdata);
    end
    data_ready = 1'b0;
    tick();
    n_cmp++;
    if (data_read !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ack_width: data_read=%b required 0", data_read);
    end
    $display("test_reset_mid_ack done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_rst = 1'b1;
    rx_data = 8'h00;
    data_ready = 1'b0;
    framing_error = 1'b0;
    overrun_error = 1'b0;
    pop = 1'b0;
    clr_err = 1'b0;
    test_reset();
    test_single();
    test_fill_stall();
    test_wrap();
    test_errors();
    test_simultaneous();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_fifo_drain.md
Name: rx_fifo_drain

Overview:
- Stage directly downstream of the UART receiver. Drains the receiver's single-byte output buffer through its data_ready/data_read handshake into a DEPTH-entry FIFO.
- Each entry is tagged with the framing_error status present at capture. The overrun condition is latched into a sticky flag.
- Presents show-ahead data to the bus/host logic, which pops entries at its own pace.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1) (4 at default), width of the occupancy count.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset, synchronous, active-high.
- rx_data  input  8  received byte from the receiver buffer.
- data_ready  input  1  receiver buffer holds an unread byte.
- framing_error  input  1  stop-bit error for the byte in the buffer.
- overrun_error  input  1  receiver overrun indication.
- data_read  output  1  one-cycle acknowledge to the receiver buffer.
- pop  input  1  consumer removes the head entry.
- clr_err  input  1  clears the sticky error flags.
- fifo_rdata  output  8  head entry data; show-ahead.
- fifo_ferr  output  1  framing tag of the head entry.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  CNT_W  current occupancy.
- ovr_sticky  output  1  overrun_error was seen since the last clear.
- unf_sticky  output  1  pop was issued while empty.

Behaviour:
- Reset, sampled at a clk edge with n_rst=1:
  - state=IDLE; wptr=rptr=0; count=0.
  - data_read=0; ovr_sticky=0; unf_sticky=0.
  - empty=1; full=0.
  - fifo_rdata and fifo_ferr are don't-care while empty; storage is not cleared.
  - Reset overrides every other input in the same cycle, including mid-ACK.
- Capture FSM, two states; data_read is registered and equals (state==ACK):
  - IDLE: if data_ready=1 and full=0, write {framing_error, rx_data} to mem[wptr], increment wptr (wraps DEPTH-1 -> 0) and go to ACK. Otherwise stay in IDLE.
  - ACK: data_read=1 for exactly this cycle; data_ready is ignored; unconditionally return to IDLE. The receiver clears data_ready at the end of the ACK cycle, so in IDLE data_ready always refers to a new byte.
  - Maximum throughput is one byte per 2 clk.
  - If full=1 in IDLE, no write and no data_read. The byte stays in the receiver buffer, and any later overrun is the receiver's responsibility.
- Pop side:
  - fifo_rdata/fifo_ferr = mem[rptr], combinational from storage.
  - pop=1 and empty=0: rptr increments with wrap.
  - pop=1 and empty=1: no pointer change; unf_sticky is set next cycle.
- count/full/empty:
  - Registered, updated at the same edge as the pointers.
  - count += push − pop_ok, where push = (IDLE & data_ready & ~full) and pop_ok = (pop & ~empty), both evaluated on the current-cycle values.
- Simultaneous push and pop:
  - When full: pop proceeds; push is blocked because full is sampled this cycle. Capture occurs in the next IDLE cycle.
  - When empty: push proceeds; pop is ignored and sets unf_sticky.
  - Otherwise both proceed and count is unchanged.
- Sticky flags:
  - ovr_sticky is set on any cycle with overrun_error=1.
  - clr_err=1 clears both sticky flags. If a set and a clear occur in the same cycle, set wins.
- Wrap: the pointers are log2(DEPTH) bits wide and wrap naturally. full/empty are derived from count, never from pointer equality.
- No combinational path from inputs to data_read.

Test Plan:
- Single byte: rx_data=0xA5, data_ready=1 in IDLE → data_read=1 exactly 1 cycle later for 1 cycle; count=1, empty=0, fifo_rdata=0xA5, fifo_ferr=0. pop → empty=1, count=0.
- Fill and stall: feed 8 bytes 0x01..0x08, then hold 0x09 with data_ready=1 → full=1, count=8, and data_read stays 0 for 20 cycles. One pop → fifo_rdata becomes 0x02, and 0x09 is captured with data_read pulsing within 2 cycles. Subsequent pops return 0x02..0x09 in order.
- Wrap-around: 3 pushes and 3 pops, then 8 pushes 0x10..0x17 → pointers wrap, reads return 0x10..0x17 in order, and count tracks each step.
- Error tags: byte 0x3C with framing_error=1 → fifo_ferr=1 at head. overrun_error pulse → ovr_sticky=1. pop on empty → unf_sticky=1. clr_err with an overrun_error pulse in the same cycle → ovr_sticky stays 1. clr_err alone → both flags 0.
- Simultaneous push and pop at count=3 → count stays 3 and the data order is preserved. At count=0 → count=1 and unf_sticky=1.
- Reset mid-ACK: assert n_rst during the ACK cycle → next cycle data_read=0, count=0, empty=1, sticky flags 0. With data_ready still 1 after n_rst deasserts → byte captured, data_read pulses 1 cycle later.
